// File: rtl/fmac_pkg.sv
// Shared types and constants for the floating-point MAC controller.
// The state encoding is used by fmac_ctrl; the sizes are defaults for its parameters.
package fmac_pkg;
  localparam int SIG_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam int LEN_W_DEF = 8;
  localparam int EXP_MAX   = 255;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_MUL,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_WB,
    S_DONE
  } state_t;
endpackage

// File: rtl/fmac_lod.sv
// Combinational leading-one encoder: index of the highest set bit of sig.
// An all-zero input encodes as 0; the caller tells it apart from bit 0 separately.
module fmac_lod
  import fmac_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic [SIG_W-1:0] sig,
  output logic [7:0]       idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < SIG_W; i++) begin
      if (sig[i]) idx = 8'(i);
    end
  end

endmodule

// File: rtl/fmac_ctrl.sv
// Sequencer for the FP MAC datapath: steps one operand pair at a time through
// mul/align/add/norm/writeback, drives normalizer controls and tracks exponent range flags.
module fmac_ctrl
  import fmac_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [SIG_W-1:0] sum_sig,
  input  logic             sum_ov,
  input  logic [EXP_W-1:0] cur_exp,
  output logic             acc_clr,
  output logic             mul_en,
  output logic             align_en,
  output logic             add_en,
  output logic             norm_en,
  output logic             acc_we,
  output logic [7:0]       nor_count,
  output logic             nor_ov,
  output logic             zero_res,
  output logic             exp_uf,
  output logic             exp_of,
  output logic [LEN_W-1:0] mac_idx,
  output logic             busy,
  output logic             done
);

  // Two guard bits so cur_exp+1 and cur_exp-(SIG_W-1) both fit without wrapping.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S  = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] EXP_ZERO_S = '0;

  state_t                 state, state_n;
  logic [LEN_W-1:0]       len_q;
  logic [EXP_W-1:0]       cur_exp_p1;
  logic [7:0]             lod_idx;
  logic signed [EW-1:0]   e_norm;
  logic                   last_pair;

  fmac_lod #(.SIG_W(SIG_W)) u_lod (
    .sig(sum_sig),
    .idx(lod_idx)
  );

  function automatic logic signed [EW-1:0] norm_exp(
    input logic [EXP_W-1:0] ex,
    input logic [7:0]       cnt,
    input logic             ov
  );
    logic signed [EW-1:0] ex_s;
    logic signed [EW-1:0] cnt_s;
    ex_s  = signed'(EW'(ex));
    cnt_s = signed'(EW'(cnt));
    if (ov) return ex_s + EW'(1);
    return ex_s - EW'(SIG_W - 1) + cnt_s;
  endfunction

  assign e_norm    = norm_exp(cur_exp_p1, nor_count, nor_ov);
  assign last_pair = (mac_idx + LEN_W'(1)) == len_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_n = (len == '0) ? S_DONE : S_CLR;
        S_CLR:   state_n = S_LOAD;
        S_LOAD:  if (op_valid && op_ready) state_n = S_MUL;
        S_MUL:   state_n = S_ALIGN;
        S_ALIGN: state_n = S_ADD;
        S_ADD:   state_n = S_NORM;
        S_NORM:  state_n = S_WB;
        S_WB:    state_n = last_pair ? S_DONE : S_LOAD;
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Registered outputs: each strobe reflects the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_clr   <= 1'b0;
      op_ready  <= 1'b0;
      mul_en    <= 1'b0;
      align_en  <= 1'b0;
      add_en    <= 1'b0;
      norm_en   <= 1'b0;
      acc_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nor_count <= '0;
      nor_ov    <= 1'b0;
      zero_res  <= 1'b0;
      exp_uf    <= 1'b0;
      exp_of    <= 1'b0;
      mac_idx   <= '0;
    end else begin
      acc_clr  <= state_n == S_CLR;
      op_ready <= state_n == S_LOAD;
      mul_en   <= state_n == S_MUL;
      align_en <= state_n == S_ALIGN;
      add_en   <= state_n == S_ADD;
      norm_en  <= state_n == S_NORM;
      acc_we   <= state_n == S_WB;
      busy     <= (state_n != S_IDLE) && (state_n != S_DONE);
      done     <= state_n == S_DONE;
      if (state == S_IDLE && start) begin
        mac_idx <= '0;
        exp_uf  <= 1'b0;
        exp_of  <= 1'b0;
      end
      if (state == S_ADD && !abort) begin
        nor_ov    <= sum_ov;
        nor_count <= lod_idx;
        zero_res  <= (sum_sig == '0) && !sum_ov;
      end
      // A zero sum has no meaningful exponent, so it never raises a range flag.
      if (state == S_NORM && !abort && !zero_res) begin
        if (e_norm <= EXP_ZERO_S) exp_uf <= 1'b1;
        if (e_norm >= EXP_MAX_S)  exp_of <= 1'b1;
      end
      if (state == S_WB && !abort) mac_idx <= mac_idx + LEN_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) len_q <= len;
    if (state == S_ADD)           cur_exp_p1 <= cur_exp;
  end

endmodule

// File: tb/tb_fmac_ctrl.sv
// Directed bench for fmac_ctrl: a queue of expected writeback results is filled as
// operand pairs are offered and drained whenever acc_we is observed.
module tb_fmac_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        op_valid;
  logic        op_ready;
  logic [23:0] sum_sig;
  logic        sum_ov;
  logic [7:0]  cur_exp;
  logic        acc_clr, mul_en, align_en, add_en, norm_en, acc_we;
  logic [7:0]  nor_count;
  logic        nor_ov, zero_res, exp_uf, exp_of;
  logic [7:0]  mac_idx;
  logic        busy, done;

  typedef struct {
    logic [7:0] cnt;
    logic       ov;
    logic       zr;
    logic [7:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_we     = 0;
  int   n_done   = 0;
  int   n_clr    = 0;
  int   pair_no  = 0;
  logic m_uf, m_of;

  fmac_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .sum_sig(sum_sig), .sum_ov(sum_ov),
    .cur_exp(cur_exp), .acc_clr(acc_clr), .mul_en(mul_en), .align_en(align_en),
    .add_en(add_en), .norm_en(norm_en), .acc_we(acc_we), .nor_count(nor_count),
    .nor_ov(nor_ov), .zero_res(zero_res), .exp_uf(exp_uf), .exp_of(exp_of),
    .mac_idx(mac_idx), .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (acc_we === 1'b1) begin
      n_we++;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_nor_count", nor_count, e.cnt);
        check("wb_nor_ov",    nor_ov,    e.ov);
        check("wb_zero_res",  zero_res,  e.zr);
        check("wb_mac_idx",   mac_idx,   e.idx);
      end
    end
    if (done === 1'b1)    n_done++;
    if (acc_clr === 1'b1) n_clr++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] lod_model(input logic [23:0] s);
    for (int i = 23; i >= 0; i--) if (s[i]) return 8'(i);
    return 8'd0;
  endfunction

  task automatic model_push(input logic [23:0] s, input logic ov, input logic [7:0] ex);
    exp_t e;
    int   en;
    e.cnt = lod_model(s);
    e.ov  = ov;
    e.zr  = (s == 0) && !ov;
    e.idx = 8'(pair_no);
    sb.push_back(e);
    en = ov ? int'(ex) + 1 : int'(ex) - 23 + int'(e.cnt);
    if (!e.zr) begin
      if (en <= 0)   m_uf = 1'b1;
      if (en >= 255) m_of = 1'b1;
    end
    pair_no++;
  endtask

  task automatic start_run(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    m_uf  = 1'b0;
    m_of  = 1'b0;
    pair_no = 0;
    tick();
    start = 1'b0;
  endtask

  // Waits for op_ready, optionally holds op_valid low, then hands over one pair.
  task automatic do_pair(input logic [23:0] s, input logic ov, input logic [7:0] ex, input int stall);
    int k;
    op_valid = 1'b0;
    k = 0;
    while (op_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("op_ready_wait", op_ready, 1);
    check("load_mac_idx", mac_idx, pair_no);
    for (int j = 0; j < stall; j++) begin
      tick();
      check("stall_ready", {op_ready, mul_en}, 2'b10);
    end
    sum_sig  = s;
    sum_ov   = ov;
    cur_exp  = ex;
    op_valid = 1'b1;
    model_push(s, ov, ex);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check("done_seen", done, 1);
    check("done_busy", busy, 0);
    tick();
    check("done_pulse_end", done, 0);
  endtask

  initial begin
    int clr0, we0, done0;
    reset = 1'b1; start = 1'b0; len = '0; abort = 1'b0; op_valid = 1'b0;
    sum_sig = '0; sum_ov = 1'b0; cur_exp = '0;
    m_uf = 1'b0; m_of = 1'b0;
    repeat (3) tick();
    check("rst_strobes", {acc_clr, op_ready, mul_en, align_en, add_en, norm_en, acc_we, busy, done}, 0);
    check("rst_nor", {nor_count, nor_ov, zero_res, exp_uf, exp_of}, 0);
    check("rst_mac_idx", mac_idx, 0);
    reset = 1'b0;
    tick();

    // len=1 cycle by cycle, op_valid already high when LOAD is reached
    start_run(8'd1);
    check("t1_clr", {acc_clr, busy, op_ready}, 3'b110);
    sum_sig = 24'h000100; sum_ov = 1'b0; cur_exp = 8'd10; op_valid = 1'b1;
    model_push(24'h000100, 1'b0, 8'd10);
    tick(); check("t1_load", {acc_clr, op_ready}, 2'b01);
    tick(); op_valid = 1'b0; check("t1_mul", {op_ready, mul_en}, 2'b01);
    tick(); check("t1_align", {mul_en, align_en}, 2'b01);
    tick(); check("t1_add", {align_en, add_en}, 2'b01);
    tick(); check("t1_norm", {add_en, norm_en}, 2'b01);
    check("t1_nor_count", nor_count, 8);
    tick(); check("t1_wb", {norm_en, acc_we}, 2'b01);
    check("t1_exp_uf", {exp_uf, exp_of}, 2'b10);
    tick(); check("t1_done", {done, busy, acc_we}, 3'b100);
    check("t1_mac_idx", mac_idx, 1);
    tick(); check("t1_idle", {done, busy}, 2'b00);
    check("t1_done_cnt", n_done, 1);
    check("t1_clr_cnt", n_clr, 1);

    // overflow pair then zero-sum pair; flags from the previous run are cleared
    start_run(8'd2);
    do_pair(24'h800000, 1'b1, 8'd254, 0);
    do_pair(24'h000000, 1'b0, 8'd0, 0);
    wait_done(20);
    check("t2_flags", {exp_uf, exp_of}, {m_uf, m_of});
    check("t2_mac_idx", mac_idx, 2);

    // three pairs with a 4-cycle gap before the second
    start_run(8'd3);
    do_pair(24'($urandom()), 1'b0, 8'd100, 0);
    do_pair(24'($urandom()), 1'b0, 8'd100, 4);
    do_pair(24'($urandom()), 1'b0, 8'd100, 0);
    wait_done(20);
    check("t3_mac_idx", mac_idx, 3);
    check("t3_flags", {exp_uf, exp_of}, {m_uf, m_of});
    check("t3_done_cnt", n_done, 3);

    // abort during ALIGN, then a normal run
    we0 = n_we; done0 = n_done;
    start_run(8'd2);
    do_pair(24'h000010, 1'b0, 8'd50, 0);
    tick(); check("t4_align", align_en, 1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("t4_idle", {busy, align_en, add_en, acc_we, done}, 0);
    sb.delete();
    repeat (8) tick();
    check("t4_no_we", n_we, we0);
    check("t4_no_done", n_done, done0);
    start_run(8'd1);
    do_pair(24'h0000FF, 1'b0, 8'd40, 0);
    wait_done(20);
    check("t4_rerun_idx", mac_idx, 1);

    // len=0 goes straight to DONE without clearing the accumulator
    clr0 = n_clr;
    start_run(8'd0);
    check("t5_done", {done, busy, acc_clr}, 3'b100);
    tick();
    check("t5_idle", {done, busy}, 2'b00);
    check("t5_no_clr", n_clr, clr0);

    // start while busy is ignored
    we0 = n_we;
    start_run(8'd2);
    start = 1'b1; len = 8'd7;
    repeat (3) tick();
    start = 1'b0;
    do_pair(24'h001000, 1'b0, 8'd60, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    do_pair(24'h020000, 1'b0, 8'd60, 0);
    wait_done(20);
    check("t6_mac_idx", mac_idx, 2);
    check("t6_we_cnt", n_we - we0, 2);

    // reset while in NORM
    start_run(8'd1);
    do_pair(24'h400000, 1'b0, 8'd1, 0);
    tick(); tick(); tick();
    check("t7_norm", norm_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_rst_strobes", {acc_clr, op_ready, mul_en, align_en, add_en, norm_en, acc_we, busy, done}, 0);
    check("t7_rst_nor", {nor_count, nor_ov, zero_res, exp_uf, exp_of, mac_idx}, 0);
    sb.delete();
    tick();

    // len=255 runs to mac_idx 255 without wrapping
    done0 = n_done;
    start_run(8'd255);
    for (int i = 0; i < 255; i++) do_pair(24'd1 << (i % 24), 1'b0, 8'd30, 0);
    wait_done(20);
    check("t8_mac_idx", mac_idx, 255);
    check("t8_done_cnt", n_done - done0, 1);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
